// File: rtl/updown_count_decoder.sv
// updown_count_decoder: receive side of the synchronous up/down counter link.
// Samples the CW-bit count word, infers step direction, accumulates a signed
// position, reports wrap-around and illegal jumps, and re-locks after
// RESYNC_N consecutive legal samples.
// Optional feature: define ERR_COUNT_EN to add the saturating 8-bit err_cnt output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNLOCKED | no reference sample yet; the first valid sample only seeds prev
// LOCKED   | tracking; UP/DOWN steps move pos, ILLEGAL goes to FAULT
// FAULT    | pos frozen; counting legal samples until resync completes
module updown_count_decoder #(
  parameter int CW       = 3,
  parameter int POS_W    = 16,
  parameter int RESYNC_N = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             valid_in,
  input  logic [CW-1:0]    q_in,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             step_valid,
  output logic             wrap,
  output logic             step_err,
`ifdef ERR_COUNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic             locked
);

  localparam int RS_W = $clog2(RESYNC_N + 1);
  localparam logic [CW-1:0] MAX_W = {CW{1'b1}};
  localparam logic [RS_W-1:0] RS_DONE = RS_W'(RESYNC_N);

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_LOCKED   = 2'd1,
    S_FAULT    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     prev_q, prev_d;
  logic [RS_W-1:0]   rs_cnt_q, rs_cnt_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              step_valid_q, step_valid_d;
  logic              wrap_q, wrap_d;
  logic              step_err_q, step_err_d;
  logic              locked_q, locked_d;
`ifdef ERR_COUNT_EN
  logic [7:0]        err_cnt_q, err_cnt_d;
`endif

  logic [CW-1:0] delta;
  logic          is_hold, is_up, is_down;

  // Classify the modular difference between the new word and the previous one.
  always_comb begin
    delta   = q_in - prev_q;
    is_hold = (delta == '0);
    is_up   = (delta == CW'(1));
    is_down = (delta == MAX_W);
  end

  // Next-state and next-output computation; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    rs_cnt_d     = rs_cnt_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    step_valid_d = 1'b0;
    wrap_d       = 1'b0;
    step_err_d   = 1'b0;

    if (valid_in) begin
      prev_d = q_in;
      case (state_q)
        S_UNLOCKED: begin
          state_d = S_LOCKED;
        end
        S_LOCKED: begin
          if (is_up) begin
            pos_d        = pos_q + POS_W'(1);
            dir_d        = 1'b0;
            step_valid_d = 1'b1;
            wrap_d       = (prev_q == MAX_W) && (q_in == '0);
          end else if (is_down) begin
            pos_d        = pos_q - POS_W'(1);
            dir_d        = 1'b1;
            step_valid_d = 1'b1;
            wrap_d       = (prev_q == '0) && (q_in == MAX_W);
          end else if (!is_hold) begin
            step_err_d = 1'b1;
            rs_cnt_d   = '0;
            state_d    = S_FAULT;
          end
        end
        S_FAULT: begin
          if (is_hold || is_up || is_down) begin
            // The sample that completes resync only re-arms tracking; pos stays put.
            if (rs_cnt_q + RS_W'(1) >= RS_DONE) begin
              rs_cnt_d = '0;
              state_d  = S_LOCKED;
            end else begin
              rs_cnt_d = rs_cnt_q + RS_W'(1);
            end
          end else begin
            step_err_d = 1'b1;
            rs_cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_UNLOCKED;
        end
      endcase
    end

    locked_d = (state_d == S_LOCKED);
  end

`ifdef ERR_COUNT_EN
  // Saturating count of illegal jumps; only clr brings it back to zero.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (step_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end
`endif

  // Register state and outputs; synchronous clr wins over everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_UNLOCKED;
      prev_q       <= '0;
      rs_cnt_q     <= '0;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      step_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      step_err_q   <= 1'b0;
      locked_q     <= 1'b0;
`ifdef ERR_COUNT_EN
      err_cnt_q    <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      rs_cnt_q     <= rs_cnt_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      step_valid_q <= step_valid_d;
      wrap_q       <= wrap_d;
      step_err_q   <= step_err_d;
      locked_q     <= locked_d;
`ifdef ERR_COUNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign pos        = pos_q;
  assign dir        = dir_q;
  assign step_valid = step_valid_q;
  assign wrap       = wrap_q;
  assign step_err   = step_err_q;
  assign locked     = locked_q;
`ifdef ERR_COUNT_EN
  assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_updown_count_decoder.sv
// Bench for updown_count_decoder: integer-arithmetic reference model checked
// every cycle, plus literal expectations at the points the test plan names.
module tb_updown_count_decoder;

  localparam int CW       = 3;
  localparam int POS_W    = 16;
  localparam int RESYNC_N = 2;
  localparam int M        = 1 << CW;
  localparam int PM       = 1 << POS_W;

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic             valid_in = 1'b0;
  logic [CW-1:0]    q_in = '0;
  logic [POS_W-1:0] pos;
  logic             dir, step_valid, wrap, step_err, locked;
`ifdef ERR_COUNT_EN
  logic [7:0]       err_cnt;
`endif

  updown_count_decoder #(.CW(CW), .POS_W(POS_W), .RESYNC_N(RESYNC_N)) dut (
    .clk        (clk),
    .clr        (clr),
    .valid_in   (valid_in),
    .q_in       (q_in),
    .pos        (pos),
    .dir        (dir),
    .step_valid (step_valid),
    .wrap       (wrap),
    .step_err   (step_err),
`ifdef ERR_COUNT_EN
    .err_cnt    (err_cnt),
`endif
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: position as an integer mod 2^POS_W, state as flags.
  bit m_on = 0;
  bit m_seen, m_locked;
  int m_prev, m_good, m_pos, m_dir, m_sv, m_wrap, m_err, m_ecnt;

  always @(posedge clk) begin
    int d;
    m_sv = 0; m_wrap = 0; m_err = 0;
    if (clr) begin
      m_on = 1; m_seen = 0; m_locked = 0; m_prev = 0; m_good = 0;
      m_pos = 0; m_dir = 0; m_ecnt = 0;
    end else if (m_on && valid_in) begin
      d = (int'(q_in) - m_prev + M) % M;
      if (!m_seen) begin
        m_seen = 1; m_locked = 1;
      end else if (m_locked) begin
        if (d == 1) begin
          m_pos = (m_pos + 1) % PM; m_dir = 0; m_sv = 1;
          m_wrap = (m_prev == M - 1 && q_in == 0) ? 1 : 0;
        end else if (d == M - 1) begin
          m_pos = (m_pos + PM - 1) % PM; m_dir = 1; m_sv = 1;
          m_wrap = (m_prev == 0 && int'(q_in) == M - 1) ? 1 : 0;
        end else if (d != 0) begin
          m_err = 1; m_locked = 0; m_good = 0;
        end
      end else begin
        if (d == 0 || d == 1 || d == M - 1) begin
          m_good++;
          if (m_good == RESYNC_N) begin m_locked = 1; m_good = 0; end
        end else begin
          m_err = 1; m_good = 0;
        end
      end
      if (m_err == 1 && m_ecnt < 255) m_ecnt++;
      m_prev = int'(q_in);
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("pos", int'(pos), m_pos);
      chk("dir", int'(dir), m_dir);
      chk("step_valid", int'(step_valid), m_sv);
      chk("wrap", int'(wrap), m_wrap);
      chk("step_err", int'(step_err), m_err);
      chk("locked", int'(locked), int'(m_locked));
`ifdef ERR_COUNT_EN
      chk("err_cnt", int'(err_cnt), m_ecnt);
`endif
    end
  end

  // Drive one cycle of inputs right after a falling edge, return at the next one.
  task automatic cyc(input bit c, input bit v, input int q);
    logic [31:0] qv;
    qv = q;
    clr = c; valid_in = v; q_in = qv[CW-1:0];
    @(negedge clk);
  endtask

  task automatic samp(input int q);
    cyc(1'b0, 1'b1, q);
  endtask

  task automatic reset_dut();
    cyc(1'b1, 1'b0, 0);
  endtask

  initial begin
    @(negedge clk);
    // Reset
    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 0);
    chk("rst_pos", int'(pos), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_pulses", int'({step_valid, wrap, step_err}), 0);

    // Lock and count up through the 7->0 wrap
    samp(5);
    chk("up_lock", int'(locked), 1);
    chk("up_lock_pos", int'(pos), 0);
    samp(6); samp(7);
    chk("up_nowrap", int'(wrap), 0);
    samp(0);
    chk("up_wrap", int'(wrap), 1);
    samp(1);
    chk("up_wrap_end", int'(wrap), 0);
    chk("up_pos", int'(pos), 4);
    chk("up_dir", int'(dir), 0);

    // Count down through 0->7, then reverse
    reset_dut();
    samp(2); samp(1); samp(0);
    samp(7);
    chk("dn_wrap", int'(wrap), 1);
    samp(6);
    chk("dn_pos", int'(pos), 16'hFFFC);
    chk("dn_dir", int'(dir), 1);
    samp(7); samp(0);
    chk("rev_pos", int'(pos), 16'hFFFE);
    chk("rev_dir", int'(dir), 0);

    // Illegal jump and resync
    reset_dut();
    samp(3); samp(6);
    chk("ill_err", int'(step_err), 1);
    chk("ill_locked", int'(locked), 0);
    chk("ill_pos", int'(pos), 0);
    samp(7);
    chk("rs1_locked", int'(locked), 0);
    samp(0);
    chk("rs2_locked", int'(locked), 1);
    chk("rs2_pos", int'(pos), 0);
    samp(1);
    chk("rs_step_pos", int'(pos), 1);

    // Illegal while in FAULT restarts the resync count
    samp(5);
    samp(6);
    samp(2);
    chk("flt_ill_err", int'(step_err), 1);
    samp(3);
    chk("flt_rs1", int'(locked), 0);
    samp(4);
    chk("flt_rs2", int'(locked), 1);
    chk("flt_pos", int'(pos), 1);

    // Holds and gaps
    reset_dut();
    samp(4);
    samp(4);
    cyc(1'b0, 1'b0, 0);
    samp(4);
    cyc(1'b0, 1'b0, 5);
    cyc(1'b0, 1'b0, 1);
    chk("hold_pos", int'(pos), 0);
    chk("hold_err", int'(step_err), 0);
    samp(5);
    chk("hold_step_pos", int'(pos), 1);
    chk("hold_step_sv", int'(step_valid), 1);

    // Reset mid-operation with an illegal sample on the same edge
    reset_dut();
    samp(0);
    for (int i = 1; i <= 10; i++) samp(i % M);
    chk("mid_pos10", int'(pos), 10);
    cyc(1'b1, 1'b1, 6);
    chk("mid_pos", int'(pos), 0);
    chk("mid_locked", int'(locked), 0);
    chk("mid_err", int'(step_err), 0);
`ifdef ERR_COUNT_EN
    chk("mid_ecnt", int'(err_cnt), 0);
`endif
    cyc(1'b0, 1'b0, 0);

    // Position boundary 0x7FFF -> 0x8000
    reset_dut();
    samp(0);
    for (int i = 1; i < 32768; i++) samp(i % M);
    chk("pos_7fff", int'(pos), 16'h7FFF);
    samp(32768 % M);
    chk("pos_8000", int'(pos), 16'h8000);

`ifdef ERR_COUNT_EN
    // Error counter saturation
    reset_dut();
    samp(0);
    for (int i = 0; i < 260; i++) samp((i % 2 == 0) ? 4 : 0);
    chk("ecnt_sat", int'(err_cnt), 255);
`endif

    cyc(1'b0, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
